// File: rtl/unified_memory_responder_pkg.sv
// Shared types and constants for the unified memory responder.
//   fetch_state_t       : states of the instruction-fetch latency FSM
//   DEFAULT_*_ADDR      : default byte addresses of the memory-mapped registers
//   idxWidth()          : word-index width for a RAM of the given depth
package unified_memory_responder_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_DONE
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_LED_ADDR    = 32'hFFFF_FF00;
  localparam logic [31:0] DEFAULT_BUTTON_ADDR = 32'hFFFF_FF04;

  function automatic int idxWidth(input int words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/unified_memory_responder_mmio.sv
// Memory-mapped button/LED registers (built only with UNIFIED_MEMORY_RESPONDER_MMIO_EN).
//   clk, rst         : clock, asynchronous active-low reset
//   writeEnable      : data-port write strobe
//   address, dataIn  : data-port byte address and write data
//   button           : raw asynchronous push-button
//   hit              : address decodes to one of the registers
//   readData         : register read value (valid when hit)
//   led              : 6-bit LED register
module mmio_peripheral
  import unified_memory_responder_pkg::*;
#(
  parameter logic [31:0] LED_ADDR    = DEFAULT_LED_ADDR,
  parameter logic [31:0] BUTTON_ADDR = DEFAULT_BUTTON_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        writeEnable,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  input  logic        button,
  output logic        hit,
  output logic [31:0] readData,
  output logic [5:0]  led
);

  logic ledHit;
  logic buttonHit;
  logic buttonMeta;
  logic buttonSync;
  logic unusedDataIn;

  assign ledHit       = (address == LED_ADDR);
  assign buttonHit    = (address == BUTTON_ADDR);
  assign hit          = ledHit | buttonHit;
  assign unusedDataIn = ^dataIn[31:6];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led        <= '0;
      buttonMeta <= 1'b0;
      buttonSync <= 1'b0;
    end else begin
      // Two-flop synchroniser: the button is asynchronous to clk.
      buttonMeta <= button;
      buttonSync <= buttonMeta;
      if (writeEnable && ledHit) led <= dataIn[5:0];
    end
  end

  always_comb begin
    readData = '0;
    if (ledHit)         readData = {26'b0, led};
    else if (buttonHit) readData = {31'b0, buttonSync};
  end

endmodule

// File: rtl/unified_memory_responder.sv
// Responder for the CPU instruction-fetch and data-memory ports over one shared
// word RAM. Data accesses complete in the same cycle and take priority; fetches
// go through a latency-modelling FSM whose success flag feeds the CPU stall logic.
// Optional MMIO button/LED registers: define UNIFIED_MEMORY_RESPONDER_MMIO_EN.
//   clk, rst                      : clock, asynchronous active-low reset
//   dataMemoryWrite/ReadEnable    : data-port strobes
//   dataMemoryAddress/DataIn      : data byte address / write data
//   dataMemoryDataOut             : combinational read data (0 when not reading)
//   instructionMemoryAddress      : fetch byte address (PC)
//   instructionMemoryDataOut      : last fetched instruction
//   instructionMemorySuccess      : fetch data valid for the current PC
//   button, led                   : MMIO push-button input / LED register
module unified_memory_responder
  import unified_memory_responder_pkg::*;
#(
  parameter int          MEM_WORDS        = 1024,
  parameter int          FETCH_LATENCY    = 2,
  parameter string       INIT_FILE        = "",
  parameter logic [31:0] MMIO_LED_ADDR    = DEFAULT_LED_ADDR,
  parameter logic [31:0] MMIO_BUTTON_ADDR = DEFAULT_BUTTON_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dataMemoryWriteEnable,
  input  logic        dataMemoryReadEnable,
  input  logic [31:0] dataMemoryAddress,
  input  logic [31:0] dataMemoryDataIn,
  output logic [31:0] dataMemoryDataOut,
  input  logic [31:0] instructionMemoryAddress,
  output logic [31:0] instructionMemoryDataOut,
  output logic        instructionMemorySuccess,
  input  logic        button,
  output logic [5:0]  led
);

  localparam int         IDX_W      = idxWidth(MEM_WORDS);
  localparam logic [3:0] CNT_RELOAD = 4'(FETCH_LATENCY - 1);

  logic [31:0]      mem [MEM_WORDS];
  fetch_state_t     state;
  logic [31:0]      fetchAddr;
  logic [3:0]       cnt;
  logic [31:0]      fetchBuffer;

  logic [IDX_W-1:0] dataIdx;
  logic [IDX_W-1:0] fetchIdx;
  logic             mmioHit;
  logic [31:0]      mmioReadData;
  logic             ramWrite;
  logic             conflict;
  logic             coherenceHit;

`ifdef UNIFIED_MEMORY_RESPONDER_MMIO_EN
  mmio_peripheral #(
    .LED_ADDR    (MMIO_LED_ADDR),
    .BUTTON_ADDR (MMIO_BUTTON_ADDR)
  ) uMmio (
    .clk         (clk),
    .rst         (rst),
    .writeEnable (dataMemoryWriteEnable),
    .address     (dataMemoryAddress),
    .dataIn      (dataMemoryDataIn),
    .button      (button),
    .hit         (mmioHit),
    .readData    (mmioReadData),
    .led         (led)
  );
`else
  logic unusedInputs;
  assign mmioHit      = 1'b0;
  assign mmioReadData = '0;
  assign led          = '0;
  // Address bits outside the word index only matter for MMIO decode.
  assign unusedInputs = ^{button, dataMemoryAddress[31:IDX_W+2],
                          dataMemoryAddress[1:0], MMIO_LED_ADDR, MMIO_BUTTON_ADDR};
`endif

  // Upper address bits drop out, so accesses wrap modulo MEM_WORDS.
  assign dataIdx  = dataMemoryAddress[IDX_W+1:2];
  assign fetchIdx = fetchAddr[IDX_W+1:2];

  assign ramWrite = dataMemoryWriteEnable & ~mmioHit;
  assign conflict = dataMemoryWriteEnable | dataMemoryReadEnable;

  // A RAM write to the word being fetched/held invalidates the fetch buffer.
  assign coherenceHit = ramWrite && (dataIdx == fetchIdx) &&
                        (state == FETCH_WAIT || state == FETCH_DONE);

  always_comb begin
    dataMemoryDataOut = '0;
    if (dataMemoryReadEnable) dataMemoryDataOut = mmioHit ? mmioReadData : mem[dataIdx];
  end

  assign instructionMemorySuccess = (state == FETCH_DONE) &&
                                    (instructionMemoryAddress == fetchAddr) &&
                                    !coherenceHit;
  assign instructionMemoryDataOut = fetchBuffer;

  // RAM contents survive reset, so the write port has no reset term.
  always_ff @(posedge clk) begin
    if (ramWrite) mem[dataIdx] <= dataMemoryDataIn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH_IDLE;
      fetchAddr   <= '0;
      cnt         <= '0;
      fetchBuffer <= '0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          fetchAddr <= instructionMemoryAddress;
          cnt       <= CNT_RELOAD;
          state     <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (coherenceHit) begin
            cnt <= CNT_RELOAD;
          end else if (!conflict) begin
            // The RAM port is free only when the data side is idle.
            if (cnt == 4'd0) begin
              fetchBuffer <= mem[fetchIdx];
              state       <= FETCH_DONE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        FETCH_DONE: begin
          if (instructionMemoryAddress != fetchAddr) begin
            fetchAddr <= instructionMemoryAddress;
            cnt       <= CNT_RELOAD;
            state     <= FETCH_WAIT;
          end else if (coherenceHit) begin
            cnt   <= CNT_RELOAD;
            state <= FETCH_WAIT;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_memory_responder.sv
module tb_unified_memory_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] dAddr = '0;
  logic [31:0] dIn = '0;
  logic [31:0] dOut;
  logic [31:0] iAddr = '0;
  logic [31:0] iOut;
  logic        succ;
  logic        button = 1'b0;
  logic [5:0]  led;

  int checks = 0;
  int failures = 0;
  logic [31:0] cyc = '0;
  logic        prevSucc = 1'b0;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] expOut;
  } vec_t;
  vec_t vecs[14];

  unified_memory_responder dut (
    .clk                      (clk),
    .rst                      (rst),
    .dataMemoryWriteEnable    (we),
    .dataMemoryReadEnable     (re),
    .dataMemoryAddress        (dAddr),
    .dataMemoryDataIn         (dIn),
    .dataMemoryDataOut        (dOut),
    .instructionMemoryAddress (iAddr),
    .instructionMemoryDataOut (iOut),
    .instructionMemorySuccess (succ),
    .button                   (button),
    .led                      (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectFetch(input logic [31:0] data, input int delay);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + 32'(delay);
    sb.push_back(e);
  endtask

  // Scoreboard: every rising edge of success must match the next expected fetch.
  always @(negedge clk) begin
    if (succ && !prevSucc) begin
      if (sb.size() == 0) begin
        check("unexpected_success", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("fetch_data", iOut, e.data);
        check("fetch_cycle", cyc, e.cyc);
      end
    end
    prevSucc <= succ;
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0050_0093, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h1111_1111, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h2222_2222, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h4444_4444, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h8888_8888, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'h0050_0093};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         32'h2222_2222};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0004, 32'h3333_3333, 32'h1111_1111};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,         32'h3333_3333};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_1000, 32'hCAFE_F00D, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'hCAFE_F00D};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0050_0093, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_1003, 32'h0,         32'h0050_0093};
    vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0};

    // Reset state
    tick(3);
    check("reset_success", {31'b0, succ}, 32'd0);
    check("reset_instr", iOut, 32'd0);
    check("reset_led", {26'b0, led}, 32'd0);
    check("reset_dataout", dOut, 32'd0);

    // Data-port vectors (keeps the fetch FSM stalled by conflicts)
    rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      we = vecs[i].we; re = vecs[i].re; dAddr = vecs[i].addr; dIn = vecs[i].din;
      #1;
      check($sformatf("data_vec%0d", i), dOut, vecs[i].expOut);
      tick();
    end
    we = 1'b0; re = 1'b0;

    // Re-reset; RAM keeps its contents. Fetch address 0 held.
    rst = 1'b0;
    tick(2);
    iAddr = 32'h0;
    rst = 1'b1;
    expectFetch(32'h0050_0093, 3);
    tick(2);
    check("no_early_success", {31'b0, succ}, 32'd0);
    tick();
    check("first_fetch_success", {31'b0, succ}, 32'd1);
    check("first_fetch_data", iOut, 32'h0050_0093);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("success_held", {31'b0, succ}, 32'd1);
    end

    // Address change while in FETCH_DONE
    iAddr = 32'h4;
    #1;
    check("addr4_drop", {31'b0, succ}, 32'd0);
    expectFetch(32'h3333_3333, 3);
    tick(4);
    iAddr = 32'h8;
    #1;
    check("addr8_drop", {31'b0, succ}, 32'd0);
    check("instr_holds", iOut, 32'h3333_3333);
    expectFetch(32'h2222_2222, 3);
    tick(4);

    // Conflict cycles delay the fetch
    iAddr = 32'h10;
    expectFetch(32'h4444_4444, 5);
    tick();
    re = 1'b1; dAddr = 32'h8;
    #1;
    check("conflict_read0", dOut, 32'h2222_2222);
    tick();
    dAddr = 32'h20;
    #1;
    check("conflict_read1", dOut, 32'h8888_8888);
    tick();
    re = 1'b0;
    tick(4);
    check("addr10_data", iOut, 32'h4444_4444);

    // Coherence: write to the held word
    iAddr = 32'h20;
    expectFetch(32'h8888_8888, 3);
    tick(4);
    we = 1'b1; dAddr = 32'h24; dIn = 32'h1234_5678;
    #1;
    check("other_write_keeps", {31'b0, succ}, 32'd1);
    tick();
    dAddr = 32'h20; dIn = 32'hDEAD_BEEF;
    #1;
    check("coherence_drop", {31'b0, succ}, 32'd0);
    expectFetch(32'hDEAD_BEEF, 3);
    tick();
    we = 1'b0;
    tick(4);
    check("coherence_success", {31'b0, succ}, 32'd1);
    check("coherence_data", iOut, 32'hDEAD_BEEF);

`ifdef UNIFIED_MEMORY_RESPONDER_MMIO_EN
    we = 1'b1; dAddr = 32'hFFFF_FF00; dIn = 32'h0000_002A;
    #1;
    check("mmio_write_keeps", {31'b0, succ}, 32'd1);
    tick();
    we = 1'b0;
    check("led_value", {26'b0, led}, 32'h2A);
    re = 1'b1;
    #1;
    check("led_read", dOut, 32'h2A);
    dAddr = 32'hFFFF_FF04; button = 1'b1;
    #1;
    check("button_unsynced", dOut, 32'd0);
    tick(2);
    check("button_synced", dOut, 32'd1);
    re = 1'b0;
`endif

    // Reset asserted mid-fetch
    iAddr = 32'h0;
    tick();
    rst = 1'b0;
    #1;
    check("midreset_success", {31'b0, succ}, 32'd0);
    check("midreset_instr", iOut, 32'd0);
    check("midreset_led", {26'b0, led}, 32'd0);
    tick(2);
    rst = 1'b1;
    expectFetch(32'h0050_0093, 3);
    tick(5);
    check("post_reset_success", {31'b0, succ}, 32'd1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
